// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and default widths for mem_port_arbiter
package mem_arb_pkg;

    localparam int MEM_ARB_DATA_WIDTH = 32;
    localparam int MEM_ARB_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way one-hot grant; round-robin when MEM_ARB_RR_EN is defined, else fixed priority
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
    // ptr=1 means requester 1 is favoured on a tie
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end
`else
    wire unused_ptr = ptr;

    assign grant = valid[0] ? 2'b01 : {valid[1], 1'b0};
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two requesters sharing one single-port memory bank; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_ARB_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ARB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] addr0_b0,
    output logic                  ce0_b0,
    output logic                  we0_b0,
    output logic [DATA_WIDTH-1:0] d0_b0,
    input  logic [DATA_WIDTH-1:0] q0_b0,
    output logic                  reg_en
);

    arb_state_e state, state_nxt;
    logic [1:0] valid, grant, accept;
    logic       rr_ptr;
    logic       owner;

    assign valid = {req1_valid, req0_valid};

    rr_arb2 u_rr_arb2 (
        .valid (valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // rst_n gate keeps ready low while reset is held with a valid pending
    always_comb begin
        state_nxt  = state;
        accept     = 2'b00;
        reg_en     = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                accept = rst_n ? grant : 2'b00;
                if (|accept) state_nxt = ISSUE;
            end
            ISSUE:  state_nxt = we0_b0 ? IDLE : RDWAIT;
            RDWAIT: begin
                reg_en    = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = accept[0];
    assign req1_ready = accept[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce0_b0    <= 1'b0;
            we0_b0    <= 1'b0;
            addr0_b0  <= '0;
            d0_b0     <= '0;
            rsp_rdata <= '0;
            owner     <= 1'b0;
        end else begin
            ce0_b0 <= |accept;
            we0_b0 <= accept[0] ? req0_we : (accept[1] & req1_we);
            if (accept[1]) begin
                addr0_b0 <= req1_addr;
                d0_b0    <= req1_wdata;
                owner    <= 1'b1;
            end else if (accept[0]) begin
                addr0_b0 <= req0_addr;
                d0_b0    <= req0_wdata;
                owner    <= 1'b0;
            end
            if (reg_en) rsp_rdata <= q0_b0;
        end
    end

`ifdef MEM_ARB_RR_EN
    // after granting req0 favour req1, and vice versa
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (|accept) begin
            rr_ptr <= accept[0];
        end
    end
`else
    assign rr_ptr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] addr0_b0;
    logic          ce0_b0, we0_b0, reg_en;
    logic [DW-1:0] d0_b0;
    logic [DW-1:0] q0_b0 = '0;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_rdata  (rsp_rdata),
        .addr0_b0   (addr0_b0),
        .ce0_b0     (ce0_b0),
        .we0_b0     (we0_b0),
        .d0_b0      (d0_b0),
        .q0_b0      (q0_b0),
        .reg_en     (reg_en)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];

    always @(posedge clk) begin
        if (ce0_b0) begin
            if (we0_b0) mem[addr0_b0] <= d0_b0;
            else        q0_b0 <= mem[addr0_b0];
        end
    end

    typedef struct {
        logic          v0, we0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1, we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [1:0]    rdy;
        logic          ce, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] d;
        logic          ren;
        logic [1:0]    rsp;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic v0, logic we0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                logic v1, logic we1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                                logic [1:0] rdy, logic ce, logic we, logic [AW-1:0] addr,
                                logic [DW-1:0] d, logic ren, logic [1:0] rsp, logic [DW-1:0] rdata);
        vec_t v;
        v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.rdy = rdy; v.ce = ce; v.we = we; v.addr = addr; v.d = d;
        v.ren = ren; v.rsp = rsp; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(string tag, logic [1:0] rdy, logic ce, logic we, logic [AW-1:0] addr,
                           logic [DW-1:0] d, logic ren, logic [1:0] rsp, logic [DW-1:0] rdata);
        chk({tag, ".ready"}, 32'({req1_ready, req0_ready}), 32'(rdy));
        chk({tag, ".ce"},    32'(ce0_b0), 32'(ce));
        chk({tag, ".we"},    32'(we0_b0), 32'(we));
        chk({tag, ".addr"},  32'(addr0_b0), 32'(addr));
        chk({tag, ".d"},     d0_b0, d);
        chk({tag, ".reg_en"}, 32'(reg_en), 32'(ren));
        chk({tag, ".rsp"},   32'({rsp1_valid, rsp0_valid}), 32'(rsp));
        chk({tag, ".rdata"}, rsp_rdata, rdata);
    endtask

    task automatic drive(logic v0, logic we0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                         logic v1, logic we1, logic [AW-1:0] a1, logic [DW-1:0] d1);
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    endtask

    int grants[$];
    int rsps[$];
    logic [DW-1:0] rdatas[$];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        drive(1, 0, 8'h01, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk_out("reset", 2'b00, 0, 0, 0, 0, 0, 2'b00, 0);

        // cycle-by-cycle trace: inputs | ready ce we addr d reg_en rsp rdata
        tbl[0]  = mk(0,0,8'h00,0,          0,0,8'h00,0,            2'b00,0,0,8'h00,0,           0,2'b00,0);
        tbl[1]  = mk(1,1,8'h01,32'h1,      0,0,8'h00,0,            2'b01,0,0,8'h00,0,           0,2'b00,0);
        tbl[2]  = mk(0,0,8'h00,0,          0,0,8'h00,0,            2'b00,1,1,8'h01,32'h1,       0,2'b00,0);
        tbl[3]  = mk(0,0,8'h00,0,          1,0,8'h01,32'h77,       2'b10,0,0,8'h01,32'h1,       0,2'b00,0);
        tbl[4]  = mk(0,0,8'h00,0,          0,0,8'h00,0,            2'b00,1,0,8'h01,32'h77,      0,2'b00,0);
        tbl[5]  = mk(0,0,8'h00,0,          0,0,8'h00,0,            2'b00,0,0,8'h01,32'h77,      1,2'b00,0);
        tbl[6]  = mk(1,0,8'h01,0,          0,0,8'h00,0,            2'b00,0,0,8'h01,32'h77,      0,2'b10,32'h1);
        tbl[7]  = mk(1,0,8'h01,0,          0,0,8'h00,0,            2'b01,0,0,8'h01,32'h77,      0,2'b00,32'h1);
        tbl[8]  = mk(0,0,8'h05,0,          0,0,8'h00,0,            2'b00,1,0,8'h01,0,           0,2'b00,32'h1);
        tbl[9]  = mk(0,0,8'h05,0,          0,0,8'h00,0,            2'b00,0,0,8'h01,0,           1,2'b00,32'h1);
        tbl[10] = mk(0,0,8'h00,0,          0,0,8'h00,0,            2'b00,0,0,8'h01,0,           0,2'b01,32'h1);
        tbl[11] = mk(0,0,8'h00,0,          1,1,8'hFF,32'hDEADBEEF, 2'b10,0,0,8'h01,0,           0,2'b00,32'h1);
        tbl[12] = mk(0,0,8'h00,0,          1,0,8'hFF,32'hDEADBEEF, 2'b00,1,1,8'hFF,32'hDEADBEEF,0,2'b00,32'h1);
        tbl[13] = mk(0,0,8'h00,0,          1,0,8'hFF,32'hDEADBEEF, 2'b10,0,0,8'hFF,32'hDEADBEEF,0,2'b00,32'h1);
        tbl[14] = mk(0,0,8'h00,0,          0,0,8'h00,0,            2'b00,1,0,8'hFF,32'hDEADBEEF,0,2'b00,32'h1);
        tbl[15] = mk(0,0,8'h00,0,          0,0,8'h00,0,            2'b00,0,0,8'hFF,32'hDEADBEEF,1,2'b00,32'h1);
        tbl[16] = mk(0,0,8'h00,0,          0,0,8'h00,0,            2'b00,0,0,8'hFF,32'hDEADBEEF,0,2'b10,32'hDEADBEEF);
        tbl[17] = mk(0,0,8'h00,0,          0,0,8'h00,0,            2'b00,0,0,8'hFF,32'hDEADBEEF,0,2'b00,32'hDEADBEEF);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
                  tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
            #1;
            chk_out($sformatf("v%0d", i), tbl[i].rdy, tbl[i].ce, tbl[i].we, tbl[i].addr,
                    tbl[i].d, tbl[i].ren, tbl[i].rsp, tbl[i].rdata);
        end

        // reset asserted during RDWAIT aborts the read
        @(negedge clk);
        drive(1, 0, 8'h01, 0, 0, 0, 0, 0);
        #1 chk("abort.accept", 32'(req0_ready), 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("abort.ce", 32'(ce0_b0), 32'd1);
        @(negedge clk);
        #1 chk("abort.rdwait", 32'(reg_en), 32'd1);
        rst_n = 1'b0;
        #1 chk_out("abort.async", 2'b00, 0, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        #1 chk_out("abort.held", 2'b00, 0, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 1, 8'h03, 32'h33);
        rst_n = 1'b1;
        #1 chk("post_rst.ready", 32'({req1_ready, req0_ready}), 32'b10);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk_out("post_rst.issue", 2'b00, 1, 1, 8'h03, 32'h33, 0, 2'b00, 0);
        @(negedge clk);
        #1 chk_out("post_rst.idle", 2'b00, 0, 0, 8'h03, 32'h33, 0, 2'b00, 0);

        // both requesters reading continuously
        @(negedge clk);
        drive(1, 0, 8'h01, 0, 1, 0, 8'hFF, 0);
        for (int c = 0; c < 16; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (req0_ready && req1_ready) begin
                n_vec++; n_err++;
                $display("FAIL tie.onehot: both ready at cycle %0d", c);
            end
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp0_valid) begin rsps.push_back(0); rdatas.push_back(rsp_rdata); end
            if (rsp1_valid) begin rsps.push_back(1); rdatas.push_back(rsp_rdata); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        chk("tie.grant_count", 32'(grants.size()), 32'd4);
        chk("tie.rsp_count", 32'(rsps.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            int exp_id;
`ifdef MEM_ARB_RR_EN
            exp_id = k % 2;
`else
            exp_id = 0;
`endif
            if (k < grants.size()) chk($sformatf("tie.grant%0d", k), 32'(grants[k]), 32'(exp_id));
            if (k < rsps.size()) begin
                chk($sformatf("tie.rsp%0d", k), 32'(rsps[k]), 32'(exp_id));
                chk($sformatf("tie.rdata%0d", k), rdatas[k], (exp_id == 0) ? 32'h1 : 32'hDEADBEEF);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
